// File: rtl/car_pkg.sv
// Codes and drive state shared between the car control FSM and the motor drive unit.
// Logic-level true/false constants keep both sides agreeing on polarity.
package car_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    SPD_STOP = 3'd0,
    SPD_SLOW = 3'd1,
    SPD_MED  = 3'd2,
    SPD_HIGH = 3'd3
  } speed_code_t;

  typedef enum logic [1:0] {
    STEER_STRAIGHT = 2'd0,
    STEER_RIGHT    = 2'd1,
    STEER_LEFT     = 2'd2
  } steer_code_t;

  typedef enum logic [1:0] {
    DRV_OFF      = 2'd0,
    DRV_ARM      = 2'd1,
    DRV_RUN      = 2'd2,
    DRV_STOPPING = 2'd3
  } drv_state_t;

endpackage

// File: rtl/pwm_ramp_channel.sv
// One wheel: duty ramps toward its target on each tick, PWM compares the shared counter.
// Braking uses a larger downward step but never undershoots the target.
module pwm_ramp_channel #(
  parameter int PWM_BITS   = 8,
  parameter int BRAKE_STEP = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] tgt,
  input  logic                brake,
  input  logic                force_zero,
  input  logic                en,
  input  logic [PWM_BITS-1:0] cnt,
  output logic [PWM_BITS-1:0] cur,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cur_reg;
  logic [PWM_BITS-1:0] cur_next;
  logic [PWM_BITS-1:0] step;

  always_comb begin
    step     = brake ? PWM_BITS'(BRAKE_STEP) : PWM_BITS'(1);
    cur_next = cur_reg;
    if (cur_reg < tgt) begin
      cur_next = cur_reg + PWM_BITS'(1);
    end else if (cur_reg > tgt) begin
      cur_next = ((cur_reg - tgt) > step) ? (cur_reg - step) : tgt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cur_reg <= '0;
    end else if (force_zero) begin
      cur_reg <= '0;
    end else if (tick) begin
      cur_reg <= cur_next;
    end
  end

  assign cur = cur_reg;
  assign pwm = en & (cnt < cur_reg);

endmodule

// File: rtl/motor_drive_unit.sv
// Receives the car command interface and drives two ramped wheel PWMs, the H-bridge
// enable, the brake lamp and blinking indicators.
module motor_drive_unit
  import car_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DUTY_SLOW  = 64,
  parameter int DUTY_MED   = 128,
  parameter int DUTY_HIGH  = 224,
  parameter int TURN_SHIFT = 1,
  parameter int RAMP_DIV   = 1024,
  parameter int BRAKE_STEP = 4,
  parameter int BLINK_DIV  = 2**22,
  parameter int ARM_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       E,
  input  logic [2:0] M1,
  input  logic [1:0] M2,
  input  logic       RH,
  input  logic       TL,
  input  logic       LH,
  output logic       en_drv,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       brake_lamp,
  output logic       lamp_r,
  output logic       lamp_l,
  output logic       at_speed,
  output logic       cmd_fault
);

  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);

  logic       e_reg, rh_reg, tl_reg, lh_reg;
  logic [2:0] m1_reg;
  logic [1:0] m2_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      e_reg  <= 1'b0;
      rh_reg <= 1'b0;
      tl_reg <= 1'b0;
      lh_reg <= 1'b0;
      m1_reg <= '0;
      m2_reg <= '0;
    end else begin
      e_reg  <= E;
      rh_reg <= RH;
      tl_reg <= TL;
      lh_reg <= LH;
      m1_reg <= M1;
      m2_reg <= M2;
    end
  end

  logic [PWM_BITS-1:0] tgt, tgt_turn, tgt_l, tgt_r;
  logic                m1_bad, m2_bad;

  always_comb begin
    tgt    = '0;
    m1_bad = FALSE;
    case (m1_reg)
      SPD_STOP: tgt = '0;
      SPD_SLOW: tgt = PWM_BITS'(DUTY_SLOW);
      SPD_MED:  tgt = PWM_BITS'(DUTY_MED);
      SPD_HIGH: tgt = PWM_BITS'(DUTY_HIGH);
      default:  m1_bad = TRUE;
    endcase
    tgt_turn = tgt >> TURN_SHIFT;
    tgt_l    = tgt;
    tgt_r    = tgt;
    m2_bad   = FALSE;
    case (m2_reg)
      STEER_STRAIGHT: ;
      STEER_RIGHT:    tgt_r = tgt_turn;
      STEER_LEFT:     tgt_l = tgt_turn;
      default:        m2_bad = TRUE;
    endcase
  end

  logic fault_reg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fault_reg <= 1'b0;
    end else if (m1_bad || m2_bad) begin
      fault_reg <= 1'b1;
    end
  end

  drv_state_t          state_reg, state_next;
  logic [AW-1:0]       arm_cnt_reg, arm_cnt_next;
  logic [PWM_BITS-1:0] cur_l, cur_r;

  // The OFF->ARM transition clock counts as the first arming clock.
  always_comb begin
    state_next   = state_reg;
    arm_cnt_next = arm_cnt_reg;
    case (state_reg)
      DRV_OFF: begin
        arm_cnt_next = '0;
        if (e_reg) begin
          state_next   = DRV_ARM;
          arm_cnt_next = AW'(1);
        end
      end
      DRV_ARM: begin
        if (!e_reg) begin
          state_next   = DRV_OFF;
          arm_cnt_next = '0;
        end else if (arm_cnt_reg >= AW'(ARM_CYCLES - 1)) begin
          state_next = DRV_RUN;
        end else begin
          arm_cnt_next = arm_cnt_reg + AW'(1);
        end
      end
      DRV_RUN: begin
        if (!e_reg) state_next = DRV_STOPPING;
      end
      DRV_STOPPING: begin
        if (e_reg) begin
          state_next = DRV_RUN;
        end else if ((cur_l == '0) && (cur_r == '0)) begin
          state_next = DRV_OFF;
        end
      end
      default: state_next = DRV_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= DRV_OFF;
      arm_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      arm_cnt_reg <= arm_cnt_next;
    end
  end

  logic drv_off, stopping, run_active;

  assign drv_off    = (state_reg == DRV_OFF);
  assign stopping   = (state_reg == DRV_STOPPING);
  assign run_active = (state_reg == DRV_RUN) || stopping;

  logic [RW-1:0]       ramp_cnt_reg;
  logic                ramp_tick;
  logic [PWM_BITS-1:0] pwm_cnt_reg;

  assign ramp_tick = (ramp_cnt_reg == RW'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ramp_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
    end else begin
      ramp_cnt_reg <= ramp_tick ? '0 : ramp_cnt_reg + RW'(1);
      pwm_cnt_reg  <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  logic [PWM_BITS-1:0] tgt_w [2];
  logic [PWM_BITS-1:0] cur_w [2];
  logic                pwm_w [2];

  assign tgt_w[0] = tgt_l;
  assign tgt_w[1] = tgt_r;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      pwm_ramp_channel #(
        .PWM_BITS  (PWM_BITS),
        .BRAKE_STEP(BRAKE_STEP)
      ) u_chan (
        .clk       (clk),
        .clr       (clr),
        .tick      (ramp_tick & run_active),
        .tgt       (stopping ? '0 : tgt_w[gi]),
        .brake     (tl_reg),
        .force_zero(drv_off),
        .en        (run_active),
        .cnt       (pwm_cnt_reg),
        .cur       (cur_w[gi]),
        .pwm       (pwm_w[gi])
      );
    end
  endgenerate

  assign cur_l = cur_w[0];
  assign cur_r = cur_w[1];

  // Indicator edges are taken against the input register so the lamp lights with it.
  logic          blink_rise;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_reg;

  assign blink_rise = (RH & ~rh_reg) | (LH & ~lh_reg);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_rise) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  assign en_drv     = run_active;
  assign pwm_l      = pwm_w[0];
  assign pwm_r      = pwm_w[1];
  assign brake_lamp = tl_reg & ~drv_off;
  assign lamp_r     = rh_reg & phase_reg & ~drv_off;
  assign lamp_l     = lh_reg & phase_reg & ~drv_off;
  assign at_speed   = (state_reg == DRV_RUN) && (cur_l == tgt_l) && (cur_r == tgt_r);
  assign cmd_fault  = fault_reg;

endmodule

// File: tb/tb_motor_drive_unit.sv
// Directed phases plus random command traffic against a time-indexed behavioural model.
module tb_motor_drive_unit;

  localparam int RAMP_DIV   = 4;
  localparam int BLINK_DIV  = 8;
  localparam int ARM_CYCLES = 3;
  localparam int DUTY_SLOW  = 64;
  localparam int DUTY_MED   = 128;
  localparam int DUTY_HIGH  = 224;
  localparam int TURN_SHIFT = 1;
  localparam int BRAKE_STEP = 4;

  localparam int M_OFF = 0, M_ARM = 1, M_RUN = 2, M_STOP = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       E = 1'b0, RH = 1'b0, TL = 1'b0, LH = 1'b0;
  logic [2:0] M1 = '0;
  logic [1:0] M2 = '0;
  logic       en_drv, pwm_l, pwm_r, brake_lamp, lamp_r, lamp_l, at_speed, cmd_fault;

  always #5 clk = ~clk;

  motor_drive_unit #(
    .PWM_BITS(8), .DUTY_SLOW(DUTY_SLOW), .DUTY_MED(DUTY_MED), .DUTY_HIGH(DUTY_HIGH),
    .TURN_SHIFT(TURN_SHIFT), .RAMP_DIV(RAMP_DIV), .BRAKE_STEP(BRAKE_STEP),
    .BLINK_DIV(BLINK_DIV), .ARM_CYCLES(ARM_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .E(E), .M1(M1), .M2(M2), .RH(RH), .TL(TL), .LH(LH),
    .en_drv(en_drv), .pwm_l(pwm_l), .pwm_r(pwm_r), .brake_lamp(brake_lamp),
    .lamp_r(lamp_r), .lamp_l(lamp_l), .at_speed(at_speed), .cmd_fault(cmd_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: t is the number of clock edges since clr released; p_* are last-sampled inputs.
  int t, mode, arm_start, rise_at, cur_l_m, cur_r_m, phase_m, cnt_m;
  bit have_rise, fault_m;
  int p_e, p_m1, p_m2, p_rh, p_tl, p_lh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    else n_pass++;
  endtask

  function automatic int duty_of(input int m1);
    case (m1)
      1: return DUTY_SLOW;
      2: return DUTY_MED;
      3: return DUTY_HIGH;
      default: return 0;
    endcase
  endfunction

  function automatic int wheel_tgt(input int m1, input int m2, input int inner_code);
    int d = duty_of(m1);
    return (m2 == inner_code) ? (d >> TURN_SHIFT) : d;
  endfunction

  function automatic int ramp(input int cur, input int tgt, input int brake);
    int dn = brake ? BRAKE_STEP : 1;
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return (cur - dn < tgt) ? tgt : cur - dn;
    return cur;
  endfunction

  task automatic model_reset();
    t = 0; mode = M_OFF; arm_start = 0; rise_at = 0; have_rise = 0; fault_m = 0;
    cur_l_m = 0; cur_r_m = 0; phase_m = 0; cnt_m = 0;
    p_e = 0; p_m1 = 0; p_m2 = 0; p_rh = 0; p_tl = 0; p_lh = 0;
  endtask

  task automatic model_edge();
    int tl_t, tr_t, nmode;
    bit tick;
    if (p_m1 >= 4 || p_m2 == 3) fault_m = 1;
    tl_t = (mode == M_STOP) ? 0 : wheel_tgt(p_m1, p_m2, 2);
    tr_t = (mode == M_STOP) ? 0 : wheel_tgt(p_m1, p_m2, 1);
    tick = (t % RAMP_DIV) == RAMP_DIV - 1;
    nmode = mode;
    case (mode)
      M_OFF:  if (p_e != 0) begin nmode = M_ARM; arm_start = t; end
      M_ARM:  if (p_e == 0) nmode = M_OFF;
              else if (t - arm_start >= ARM_CYCLES - 1) nmode = M_RUN;
      M_RUN:  if (p_e == 0) nmode = M_STOP;
      default: if (p_e != 0) nmode = M_RUN;
               else if (cur_l_m == 0 && cur_r_m == 0) nmode = M_OFF;
    endcase
    if (mode == M_OFF) begin
      cur_l_m = 0; cur_r_m = 0;
    end else if (tick && (mode == M_RUN || mode == M_STOP)) begin
      cur_l_m = ramp(cur_l_m, tl_t, p_tl);
      cur_r_m = ramp(cur_r_m, tr_t, p_tl);
    end
    if ((RH && p_rh == 0) || (LH && p_lh == 0)) begin
      have_rise = 1; rise_at = t;
    end
    phase_m = have_rise ? (1 ^ (((t - rise_at) / BLINK_DIV) % 2)) : (((t + 1) / BLINK_DIV) % 2);
    cnt_m = (t + 1) % 256;
    p_e = E; p_m1 = M1; p_m2 = M2; p_rh = RH; p_tl = TL; p_lh = LH;
    mode = nmode;
    t++;
  endtask

  function automatic logic [7:0] model_outs();
    bit en, on, at;
    en = (mode == M_RUN || mode == M_STOP);
    on = (mode != M_OFF);
    at = (mode == M_RUN) && cur_l_m == wheel_tgt(p_m1, p_m2, 2) && cur_r_m == wheel_tgt(p_m1, p_m2, 1);
    return {en, en && (cnt_m < cur_l_m), en && (cnt_m < cur_r_m), on && p_tl != 0,
            on && p_rh != 0 && phase_m != 0, on && p_lh != 0 && phase_m != 0, at, fault_m};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {en_drv, pwm_l, pwm_r, brake_lamp, lamp_r, lamp_l, at_speed, cmd_fault};
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("outs", {24'd0, dut_outs()}, {24'd0, model_outs()});
      check("cur", {16'd0, dut.cur_l, dut.cur_r}, {16'd0, cur_l_m[7:0], cur_r_m[7:0]});
    end
  endtask

  initial begin
    int lat, hi;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_reset();
    run(3);
    $display("phase reset released t=%0d", t);

    // Arming latency and slow ramp
    E = 1'b1; M1 = 3'd1; M2 = 2'd0;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      run(1);
      if (en_drv) begin lat = i; break; end
    end
    check("arm_lat", lat, 1 + ARM_CYCLES);
    run(300);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      run(1);
      hi += int'(pwm_l);
    end
    check("pwm_duty", hi, DUTY_SLOW);
    $display("phase slow ramp t=%0d arm_lat=%0d duty=%0d", t, lat, hi);

    // Asynchronous clear mid-RUN
    clr = 1'b1;
    #1;
    check("clr_outs", {24'd0, dut_outs()}, 32'd0);
    check("clr_cur", {16'd0, dut.cur_l, dut.cur_r}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    $display("phase clear mid-run");

    // Medium speed, right turn, then brake to zero
    M1 = 3'd2;
    run(600);
    M2 = 2'd1;
    run(300);
    TL = 1'b1; M1 = 3'd0;
    run(200);
    $display("phase turn/brake t=%0d", t);

    // Indicators
    TL = 1'b0; RH = 1'b1;
    run(40);
    LH = 1'b1;
    run(40);
    RH = 1'b0; LH = 1'b0;
    run(10);
    $display("phase indicators t=%0d", t);

    // Stop to OFF, then stop interrupted at duty 60
    M1 = 3'd2; M2 = 2'd0;
    run(600);
    E = 1'b0;
    run(700);
    E = 1'b1;
    run(600);
    E = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      run(1);
      if (cur_l_m <= 60) break;
    end
    E = 1'b1;
    run(400);
    $display("phase stopping t=%0d", t);

    // Illegal codes leave a sticky fault
    M1 = 3'd5;
    run(30);
    M1 = 3'd1;
    run(30);
    M2 = 2'd3;
    run(30);
    M2 = 2'd0;
    run(30);
    $display("phase fault t=%0d", t);

    // Random command traffic
    for (int s = 0; s < 80; s++) begin
      E  = ($urandom_range(0, 7) != 0);
      M1 = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      M2 = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      TL = 1'($urandom_range(0, 1));
      RH = 1'($urandom_range(0, 1));
      LH = 1'($urandom_range(0, 1));
      run($urandom_range(1, 80));
    end
    $display("phase random t=%0d", t);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
